// File: rtl/cordic_host_bridge.sv
// Host-side bridge for the CORDIC execution core.
// Commands are issued to the core one per cycle, gated by credits so that the
// core (which cannot be stalled) never returns more results than the result
// FIFO can hold. Results are buffered in order and presented show-ahead on a
// valid/ready response port.
module cordic_host_bridge #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  // command port
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_arctan,
  input  logic [DATA_WIDTH-1:0]      cmd_degree,
  input  logic [DATA_WIDTH-1:0]      cmd_tan,
  // core input interface
  output logic                       core_valid_in,
  output logic                       core_arctan_en_in,
  output logic [DATA_WIDTH-1:0]      core_degree_in,
  output logic [DATA_WIDTH-1:0]      core_tan_in,
  // core output interface
  input  logic                       core_valid_out,
  input  logic                       core_arctan_en_out,
  input  logic [DATA_WIDTH-1:0]      core_degree_out,
  input  logic [DATA_WIDTH-1:0]      core_x_out,
  input  logic [DATA_WIDTH-1:0]      core_y_out,
  // response port
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_arctan,
  output logic [DATA_WIDTH-1:0]      rsp_degree,
  output logic [DATA_WIDTH-1:0]      rsp_x,
  output logic [DATA_WIDTH-1:0]      rsp_y,
  // status
  output logic [FIFO_ADDR_WIDTH:0]   credits,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_count,
  output logic                       overflow_err
);

  localparam int CW          = FIFO_ADDR_WIDTH + 1;
  localparam int ENTRY_WIDTH = 1 + 3 * DATA_WIDTH;

  localparam logic [CW-1:0]              DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]              ONE_C   = CW'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE = FIFO_ADDR_WIDTH'(1);

  // registered state
  logic [CW-1:0]              credits_q, credits_d;
  logic [CW-1:0]              count_q, count_d;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                       overflow_q, overflow_d;
  logic [ENTRY_WIDTH-1:0]     mem [FIFO_DEPTH];

  logic                       issue;
  logic                       pop;
  logic                       full;
  logic                       push_en;
  logic                       push_drop;
  logic [ENTRY_WIDTH-1:0]     push_word;
  logic [ENTRY_WIDTH-1:0]     head_word;

  // Handshake decode: cmd_ready and rsp_valid depend only on registers, so
  // there is no combinational path from cmd_valid or rsp_ready to them.
  assign cmd_ready = (credits_q != '0);
  assign rsp_valid = (count_q != '0);
  assign issue     = cmd_valid & cmd_ready;
  assign pop       = rsp_valid & rsp_ready;
  assign full      = (count_q == DEPTH_C);

  // A result arriving while full is only storable if the head leaves in the
  // same cycle; otherwise it is dropped and flagged.
  assign push_en   = core_valid_out & (~full | pop);
  assign push_drop = core_valid_out & full & ~pop;

  assign push_word = {core_arctan_en_out, core_degree_out, core_x_out, core_y_out};
  assign head_word = mem[rd_ptr_q];

  assign rsp_arctan = head_word[ENTRY_WIDTH-1];
  assign rsp_degree = head_word[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign rsp_x      = head_word[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign rsp_y      = head_word[DATA_WIDTH-1:0];

  assign credits      = credits_q;
  assign fifo_count   = count_q;
  assign overflow_err = overflow_q;

  // Next-state for credits, occupancy, pointers and the sticky error flag.
  always_comb begin
    credits_d  = credits_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;

    // Issue and pop together cancel. A pop with credits already at depth can
    // only follow a stray (unrequested) result, so it is not refunded.
    unique case ({issue, pop})
      2'b10:   credits_d = credits_q - ONE_C;
      2'b01:   if (credits_q != DEPTH_C) credits_d = credits_q + ONE_C;
      default: credits_d = credits_q;
    endcase

    unique case ({push_en, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_drop) overflow_d = 1'b1;
  end

  // Bookkeeping registers, cleared together so a mid-operation reset leaves
  // no partial state behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credits_q  <= DEPTH_C;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Result storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (reset && push_en) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  // Core input register: valid pulses for one cycle per issue, data fields
  // hold their last issued values between commands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      core_valid_in     <= 1'b0;
      core_arctan_en_in <= 1'b0;
      core_degree_in    <= '0;
      core_tan_in       <= '0;
    end else begin
      core_valid_in <= issue;
      if (issue) begin
        core_arctan_en_in <= cmd_arctan;
        core_degree_in    <= cmd_degree;
        core_tan_in       <= cmd_tan;
      end
    end
  end

endmodule

// File: tb/tb_cordic_host_bridge.sv
// Bench for cordic_host_bridge with a fixed-latency behavioural core model.
module tb_cordic_host_bridge;

  localparam int DW  = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_arctan;
  logic [DW-1:0] cmd_degree, cmd_tan;
  logic          core_valid_in, core_arctan_en_in;
  logic [DW-1:0] core_degree_in, core_tan_in;
  logic          core_valid_out, core_arctan_en_out;
  logic [DW-1:0] core_degree_out, core_x_out, core_y_out;
  logic          rsp_valid, rsp_ready, rsp_arctan;
  logic [DW-1:0] rsp_degree, rsp_x, rsp_y;
  logic [3:0]    credits, fifo_count;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_host_bridge #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .FIFO_ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_arctan(cmd_arctan),
    .cmd_degree(cmd_degree), .cmd_tan(cmd_tan),
    .core_valid_in(core_valid_in), .core_arctan_en_in(core_arctan_en_in),
    .core_degree_in(core_degree_in), .core_tan_in(core_tan_in),
    .core_valid_out(core_valid_out), .core_arctan_en_out(core_arctan_en_out),
    .core_degree_out(core_degree_out), .core_x_out(core_x_out), .core_y_out(core_y_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_arctan(rsp_arctan),
    .rsp_degree(rsp_degree), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .credits(credits), .fifo_count(fifo_count), .overflow_err(overflow_err)
  );

  // ---------------- core model ----------------
  logic          pipe_v [LAT];
  logic          pipe_a [LAT];
  logic [DW-1:0] pipe_d [LAT];
  logic [DW-1:0] pipe_t [LAT];
  logic          inj_v = 1'b0;
  logic [DW-1:0] inj_d = '0;
  logic [DW-1:0] inj_x = '0;

  function automatic logic [DW-1:0] model_x(input logic a, input logic [DW-1:0] d, input logic [DW-1:0] t);
    if (!a && d == 16'h1E00 && t == 16'h0000) return 16'h00DD;
    return d ^ 16'h00FF;
  endfunction

  function automatic logic [DW-1:0] model_y(input logic a, input logic [DW-1:0] d, input logic [DW-1:0] t);
    if (!a && d == 16'h1E00 && t == 16'h0000) return 16'h0080;
    return t + d;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < LAT; k++) pipe_v[k] <= 1'b0;
    end else begin
      pipe_v[0] <= core_valid_in;
      pipe_a[0] <= core_arctan_en_in;
      pipe_d[0] <= core_degree_in;
      pipe_t[0] <= core_tan_in;
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_a[k] <= pipe_a[k-1];
        pipe_d[k] <= pipe_d[k-1];
        pipe_t[k] <= pipe_t[k-1];
      end
    end
  end

  assign core_valid_out     = pipe_v[LAT-1] | inj_v;
  assign core_arctan_en_out = inj_v ? 1'b0  : pipe_a[LAT-1];
  assign core_degree_out    = inj_v ? inj_d : pipe_d[LAT-1];
  assign core_x_out         = inj_v ? inj_x : model_x(pipe_a[LAT-1], pipe_d[LAT-1], pipe_t[LAT-1]);
  assign core_y_out         = inj_v ? 16'h0000 : model_y(pipe_a[LAT-1], pipe_d[LAT-1], pipe_t[LAT-1]);

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; inj_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_count(input int target, input string name);
    int n = 0;
    while (int'(fifo_count) != target && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, fifo_count, target);
  endtask

  task automatic fill_fifo(input logic [DW-1:0] base);
    int acc = 0;
    int n = 0;
    rsp_ready = 1'b0;
    while (acc < 8 && n < 40) begin
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_arctan = 1'b0;
      cmd_tan    = 16'h0000;
      cmd_degree = base + DW'(acc);
      if (cmd_ready) acc++;
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_count(8, "fill_count");
  endtask

  typedef struct {
    logic          arctan;
    logic [DW-1:0] degree;
    logic [DW-1:0] tan;
    logic [DW-1:0] exp_x;
    logic [DW-1:0] exp_y;
  } vec_t;

  vec_t vecs [6];
  logic [DW:0] exp_q [$];

  initial begin
    vecs[0] = '{1'b0, 16'h1E00, 16'h0000, 16'h00DD, 16'h0080};
    vecs[1] = '{1'b0, 16'h0100, 16'h0040, 16'h01FF, 16'h0140};
    vecs[2] = '{1'b1, 16'h0000, 16'h0100, 16'h00FF, 16'h0100};
    vecs[3] = '{1'b0, 16'hFF00, 16'h0000, 16'hFFFF, 16'hFF00};
    vecs[4] = '{1'b1, 16'h2D80, 16'h7F00, 16'h2D7F, 16'hAC80};
    vecs[5] = '{1'b0, 16'h00AA, 16'h0011, 16'h0055, 16'h00BB};

    // ---- reset with cmd_valid asserted ----
    reset = 1'b0; cmd_valid = 1'b1; cmd_arctan = 1'b0;
    cmd_degree = 16'h1234; cmd_tan = 16'h5678; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_core_valid_in", core_valid_in, 0);
    chk("rst_core_degree_in", core_degree_in, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_credits", credits, 8);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_overflow", overflow_err, 0);
    cmd_valid = 1'b0;
    reset = 1'b1;

    // ---- table-driven single transactions ----
    for (int i = 0; i < 6; i++) begin
      int n;
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_arctan = vecs[i].arctan;
      cmd_degree = vecs[i].degree;
      cmd_tan    = vecs[i].tan;
      chk("vec_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("vec_core_valid_in", core_valid_in, 1);
      chk("vec_core_arctan_in", core_arctan_en_in, vecs[i].arctan);
      chk("vec_core_degree_in", core_degree_in, vecs[i].degree);
      chk("vec_core_tan_in", core_tan_in, vecs[i].tan);
      chk("vec_credits_issued", credits, 7);
      @(negedge clk);
      chk("vec_core_valid_drop", core_valid_in, 0);
      chk("vec_core_degree_hold", core_degree_in, vecs[i].degree);
      n = 0;
      while (!core_valid_out && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("vec_core_result", core_valid_out, 1);
      chk("vec_rsp_not_early", rsp_valid, 0);
      @(negedge clk);
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_arctan", rsp_arctan, vecs[i].arctan);
      chk("vec_rsp_degree", rsp_degree, vecs[i].degree);
      chk("vec_rsp_x", rsp_x, vecs[i].exp_x);
      chk("vec_rsp_y", rsp_y, vecs[i].exp_y);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("vec_credits_back", credits, 8);
      chk("vec_rsp_empty", rsp_valid, 0);
    end

    // ---- credit exhaustion ----
    do_reset();
    begin
      int acc = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_arctan = 1'b0;
        cmd_tan    = 16'h0000;
        cmd_degree = 16'h0300 + DW'(acc);
        if (cmd_ready) acc++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("exh_accepts", acc, 8);
    end
    chk("exh_cmd_ready", cmd_ready, 0);
    chk("exh_credits", credits, 0);
    wait_count(8, "exh_count");
    chk("exh_head", rsp_degree, 16'h0300);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("exh_ready_after_pop", cmd_ready, 1);
    chk("exh_credits_after_pop", credits, 1);
    chk("exh_count_after_pop", fifo_count, 7);
    chk("exh_head_after_pop", rsp_degree, 16'h0301);

    // ---- full FIFO, simultaneous push and pop ----
    cmd_valid = 1'b1; cmd_degree = 16'h0308;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_count(8, "pp_refill");
    inj_v = 1'b1; inj_d = 16'h0AB0; inj_x = 16'h5A5A;
    rsp_ready = 1'b1;
    @(negedge clk);
    inj_v = 1'b0;
    rsp_ready = 1'b0;
    chk("pp_count", fifo_count, 8);
    chk("pp_overflow", overflow_err, 0);
    chk("pp_head", rsp_degree, 16'h0302);
    rsp_ready = 1'b1;
    repeat (7) @(negedge clk);
    rsp_ready = 1'b0;
    chk("pp_inj_valid", rsp_valid, 1);
    chk("pp_inj_degree", rsp_degree, 16'h0AB0);
    chk("pp_inj_x", rsp_x, 16'h5A5A);

    // ---- overflow ----
    do_reset();
    fill_fifo(16'h0500);
    inj_v = 1'b1; inj_d = 16'h0BAD; inj_x = 16'h1111;
    @(negedge clk);
    inj_v = 1'b0;
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_head", rsp_degree, 16'h0500);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", overflow_err, 1);
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    rsp_ready = 1'b0;
    chk("ovf_dropped_gone", rsp_valid, 0);
    chk("ovf_still_sticky", overflow_err, 1);
    do_reset();
    chk("ovf_cleared", overflow_err, 0);

    // ---- wrap / order with random backpressure ----
    begin
      int issued = 0;
      int got = 0;
      int cyc = 0;
      int inflight;
      exp_q.delete();
      while ((issued < 20 || got < 20) && cyc < 2000) begin
        @(negedge clk);
        inflight = int'(core_valid_in);
        for (int k = 0; k < LAT; k++) inflight += int'(pipe_v[k]);
        chk("inv_credits", int'(credits) + int'(fifo_count) + inflight, 8);
        cmd_valid  = (issued < 20) && ($urandom_range(0, 3) != 0);
        cmd_arctan = issued[0];
        cmd_degree = 16'h0A00 + DW'(issued);
        cmd_tan    = 16'h0000;
        rsp_ready  = ($urandom_range(0, 1) == 1);
        if (cmd_valid && cmd_ready) begin
          exp_q.push_back({cmd_arctan, cmd_degree});
          issued++;
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("ord_unexpected", rsp_valid, 0);
          end else begin
            chk("ord_entry", {rsp_arctan, rsp_degree}, exp_q[0]);
            chk("ord_x", rsp_x, rsp_degree ^ 16'h00FF);
            void'(exp_q.pop_front());
          end
          got++;
        end
        cyc++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("ord_issued", issued, 20);
      chk("ord_received", got, 20);
      chk("ord_queue_empty", exp_q.size(), 0);
      chk("ord_credits_final", credits, 8);
      chk("ord_overflow", overflow_err, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_host_bridge.md
Name: cordic_host_bridge

Overview:
- Host-side counterpart of the CORDIC execution top.
- Accepts rotation/arctan commands on a valid/ready handshake and drives the core's input interface (valid, arctan enable, degree, tan) one transaction per cycle.
- Captures every core result (valid, arctan enable, degree, x, y) into an in-order result FIFO presented on a valid/ready response port.
- The core has no backpressure, so issue is credit-gated: results can never exceed FIFO space.

Parameters:
- DATA_WIDTH, 16, width of degree/tan/x/y words (signed Q7.8).
- FIFO_DEPTH, 8, result FIFO entries; must be a power of two, >= 2.
- FIFO_ADDR_WIDTH, 3, log2(FIFO_DEPTH).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  bridge can accept a command.
- cmd_arctan  input  1  1 = arctan (vectoring), 0 = rotation.
- cmd_degree  input  DATA_WIDTH  signed angle.
- cmd_tan  input  DATA_WIDTH  tan operand.
- core_valid_in  output  1  to core valid_in_interface.
- core_arctan_en_in  output  1  to core arctan_en_in_interface.
- core_degree_in  output  DATA_WIDTH  to core degree_in_interface.
- core_tan_in  output  DATA_WIDTH  to core tan_in_interface.
- core_valid_out  input  1  from core valid_out_interface.
- core_arctan_en_out  input  1  from core.
- core_degree_out, core_x_out, core_y_out  input  DATA_WIDTH each  signed core results.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_arctan  output  1  head entry arctan flag.
- rsp_degree, rsp_x, rsp_y  output  DATA_WIDTH each  head entry data.
- credits  output  FIFO_ADDR_WIDTH+1  free credits.
- fifo_count  output  FIFO_ADDR_WIDTH+1  FIFO occupancy.
- overflow_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset==0 at a clock edge):
  - credits = FIFO_DEPTH; fifo_count = 0; rd/wr pointers = 0.
  - core_valid_in = 0; core_arctan_en_in = 0; core_degree_in = 0; core_tan_in = 0.
  - rsp_valid = 0; overflow_err = 0.
  - core_valid_out is ignored while reset is low.
- Issue:
  - cmd_ready = (credits != 0), decoded from registered state only; no combinational path from cmd_valid or rsp_ready.
  - issue = cmd_valid & cmd_ready.
  - Accept at edge N -> core_valid_in = 1 and fields equal to the command for the cycle after edge N.
  - Without an issue, core_valid_in = 0 and data fields hold their last values.
  - Back-to-back issue allowed every cycle while credits remain.
- Credits:
  - credits_next = credits - issue + pop, where pop = rsp_valid & rsp_ready.
  - Issue and pop in the same cycle leave credits unchanged.
  - credits never exceeds FIFO_DEPTH and never underflows.
- Result FIFO:
  - Circular buffer of {arctan, degree, x, y} words, (1+3*DATA_WIDTH) bits each.
  - Push = core_valid_out (reset high), at wr_ptr; pointers wrap modulo FIFO_DEPTH.
  - Show-ahead: rsp_* reflect the head entry; rsp_valid = (fifo_count != 0).
  - A pushed entry is visible no earlier than the cycle after the push.
  - Push into an empty FIFO gives rsp_valid = 1 on the next cycle.
  - Push and pop together: count unchanged, both pointers advance; legal when full.
  - Push when full without pop: entry discarded, pointers and count unchanged, overflow_err set and held until reset.
  - rsp_* data are don't-care while rsp_valid = 0.
  - Order is strictly preserved: responses leave in command issue order.
- Invariant (credit accounting): credits + fifo_count + in-flight core transactions == FIFO_DEPTH.
- Reset mid-operation: all state clears in one cycle. The core must be reset concurrently; any stray result after reset is pushed normally and may raise overflow_err.

Test Plan:
- Reset: hold reset=0 for 2 cycles with cmd_valid=1 -> core_valid_in=0, cmd_ready=1, credits=8, rsp_valid=0, overflow_err=0.
- Single rotation: cmd degree=0x1E00 (30.0), tan=0, arctan=0 accepted at edge N -> core_valid_in=1, core_degree_in=0x1E00 after N. Model returns x=0x00DD, y=0x0080 -> rsp_valid=1 one cycle after push with matching data; pop -> credits back to 8.
- Credit exhaustion: rsp_ready=0, cmd_valid held -> exactly 8 accepts, then cmd_ready=0, credits=0. After all 8 results, fifo_count=8. One pop -> cmd_ready=1 the next cycle.
- Full simultaneous push/pop: FIFO full, inject core_valid_out while rsp_ready=1 -> count stays 8, no overflow_err, new entry emerges 8 pops later.
- Overflow: force core_valid_out with FIFO full and rsp_ready=0 -> entry dropped, count 8, overflow_err=1 until reset.
- Wrap/order: 20 mixed commands (tags in degree LSBs) with random rsp_ready -> responses in issue order, pointers wrap twice, credit invariant holds every cycle.
